// File: rtl/ahb_lite_master.sv
// AHB-Lite initiator: turns single commands into pipelined NONSEQ/SEQ/BUSY bursts.
// Optional data-phase timeout is compiled in when AHB_MASTER_TIMEOUT_EN is defined.
module ahb_lite_master #(
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic        HCLK,
    input  logic        HRESET_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_addr,
    input  logic        cmd_write,
    input  logic [2:0]  cmd_burst,
    input  logic [2:0]  cmd_size,
    input  logic [4:0]  cmd_len,
    input  logic [31:0] wr_data,
    input  logic        wr_valid,
    output logic        wr_ready,
    output logic [31:0] rd_data,
    output logic        rd_valid,
    output logic        done,
    output logic        err,
    output logic        err_timeout,
    output logic [1:0]  HTRANS,
    output logic [2:0]  HBURST,
    output logic [2:0]  HSIZE,
    output logic        HWRITE,
    output logic [31:0] HADDR,
    output logic [31:0] HWDATA,
    input  logic [31:0] HRDATA,
    input  logic        HREADY,
    input  logic [1:0]  HRESP
);

    localparam logic [1:0] TrIdle   = 2'b00;
    localparam logic [1:0] TrBusy   = 2'b01;
    localparam logic [1:0] TrNonseq = 2'b10;
    localparam logic [1:0] TrSeq    = 2'b11;

    localparam logic [2:0] BurstSingle = 3'b000;
    localparam logic [2:0] BurstIncr   = 3'b001;
    localparam logic [2:0] BurstWrap4  = 3'b010;
    localparam logic [2:0] BurstIncr4  = 3'b011;
    localparam logic [2:0] BurstWrap8  = 3'b100;
    localparam logic [2:0] BurstIncr8  = 3'b101;

    localparam logic [1:0] RespError = 2'b01;

    typedef enum logic [2:0] {StIdle, StAddr, StBurst, StLast, StErr} state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [4:0]  left_q, left_d;
    logic        dp_q, dp_d;
    logic        hold_q, hold_d;
    logic [31:0] hwdata_q, hwdata_d;
    logic [31:0] rd_data_q, rd_data_d;
    logic        rd_valid_q, rd_valid_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        err_to_q, err_to_d;
    logic        cmd_ready_q, cmd_ready_d;

    logic [2:0]  burst_q, size_q;
    logic        write_q;
    logic [4:0]  beats_q;

    logic        cap;
    logic        cmd_illegal;
    logic [1:0]  htrans;
    logic        accept, dp_done, dp_error;
    logic [31:0] incr_addr, wrap_mask, next_addr;
    logic        is_wrap;

    function automatic logic [4:0] beat_count(input logic [2:0] burst, input logic [4:0] len);
        case (burst)
            BurstIncr:              beat_count = len;
            BurstWrap4, BurstIncr4: beat_count = 5'd4;
            BurstWrap8, BurstIncr8: beat_count = 5'd8;
            default:                beat_count = 5'd1;
        endcase
    endfunction

    always_comb begin
        cmd_illegal = 1'b0;
        if (cmd_burst[2:1] == 2'b11) cmd_illegal = 1'b1;
        if (cmd_size > 3'd2) cmd_illegal = 1'b1;
        if (cmd_burst == BurstIncr && cmd_len == 5'd0) cmd_illegal = 1'b1;
        if (cmd_size == 3'd1 && cmd_addr[0]) cmd_illegal = 1'b1;
        if (cmd_size == 3'd2 && cmd_addr[1:0] != 2'b00) cmd_illegal = 1'b1;
    end

    // Wrapping bursts keep the upper address bits and wrap the low bits inside the block.
    assign is_wrap   = (burst_q == BurstWrap4) || (burst_q == BurstWrap8);
    assign incr_addr = addr_q + (32'd1 << size_q);
    assign wrap_mask = ({27'd0, beats_q} << size_q) - 32'd1;
    assign next_addr = is_wrap ? ((addr_q & ~wrap_mask) | (incr_addr & wrap_mask)) : incr_addr;

`ifdef AHB_MASTER_TIMEOUT_EN
    localparam logic [15:0] ToLast = 16'(TIMEOUT_CYC - 1);
    logic [15:0] to_cnt_q, to_cnt_d;

    always_ff @(posedge HCLK or negedge HRESET_n) begin
        if (!HRESET_n) to_cnt_q <= '0;
        else           to_cnt_q <= to_cnt_d;
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYC != 0);
`endif

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        left_d     = left_q;
        dp_d       = dp_q;
        hwdata_d   = hwdata_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b0;
        err_to_d   = 1'b0;
        cap        = 1'b0;

        // A write beat only goes out with data available; once driven it is held until taken.
        case (state_q)
            StAddr:  htrans = (hold_q || !write_q || wr_valid) ? TrNonseq : TrIdle;
            StBurst: htrans = (hold_q || !write_q || wr_valid) ? TrSeq : TrBusy;
            default: htrans = TrIdle;
        endcase

        dp_done  = dp_q && HREADY;
        dp_error = dp_q && (HRESP == RespError);
        accept   = HREADY && htrans[1] && !dp_error;
        hold_d   = htrans[1] && !HREADY;

        if (accept) begin
            addr_d = next_addr;
            left_d = left_q - 5'd1;
            if (write_q) hwdata_d = wr_data;
        end
        if (HREADY) dp_d = accept;
        if (dp_done && !dp_error && !write_q) begin
            rd_data_d  = HRDATA;
            rd_valid_d = 1'b1;
        end

        case (state_q)
            StIdle: begin
                if (cmd_valid && cmd_ready_q) begin
                    if (cmd_illegal) begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end else begin
                        cap     = 1'b1;
                        state_d = StAddr;
                        addr_d  = cmd_addr;
                        left_d  = beat_count(cmd_burst, cmd_len);
                    end
                end
            end
            StAddr, StBurst: begin
                if (accept) state_d = (left_q == 5'd1) ? StLast : StBurst;
            end
            StLast: begin
                if (dp_done && !dp_error) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            StErr: begin
                if (HREADY) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        // ERROR cancels the pending beat; an ERROR already completing with HREADY ends at once.
        if (dp_error && state_q != StErr) begin
            hold_d = 1'b0;
            if (HREADY) begin
                state_d = StIdle;
                done_d  = 1'b1;
                err_d   = 1'b1;
            end else begin
                state_d = StErr;
            end
        end

`ifdef AHB_MASTER_TIMEOUT_EN
        to_cnt_d = '0;
        if (dp_q && !HREADY) begin
            if (to_cnt_q == ToLast) begin
                state_d    = StIdle;
                dp_d       = 1'b0;
                hold_d     = 1'b0;
                done_d     = 1'b1;
                err_d      = 1'b1;
                err_to_d   = 1'b1;
                rd_valid_d = 1'b0;
            end else begin
                to_cnt_d = to_cnt_q + 16'd1;
            end
        end
`endif

        // Ready is withheld during the done pulse so commands never overlap.
        cmd_ready_d = (state_d == StIdle) && !done_d;
    end

    always_ff @(posedge HCLK or negedge HRESET_n) begin
        if (!HRESET_n) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            left_q      <= '0;
            dp_q        <= 1'b0;
            hold_q      <= 1'b0;
            hwdata_q    <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            err_to_q    <= 1'b0;
            cmd_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            left_q      <= left_d;
            dp_q        <= dp_d;
            hold_q      <= hold_d;
            hwdata_q    <= hwdata_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            done_q      <= done_d;
            err_q       <= err_d;
            err_to_q    <= err_to_d;
            cmd_ready_q <= cmd_ready_d;
        end
    end

    always_ff @(posedge HCLK or negedge HRESET_n) begin
        if (!HRESET_n) begin
            burst_q <= '0;
            size_q  <= '0;
            write_q <= 1'b0;
            beats_q <= '0;
        end else if (cap) begin
            burst_q <= cmd_burst;
            size_q  <= cmd_size;
            write_q <= cmd_write;
            beats_q <= beat_count(cmd_burst, cmd_len);
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign wr_ready    = accept && write_q;
    assign rd_data     = rd_data_q;
    assign rd_valid    = rd_valid_q;
    assign done        = done_q;
    assign err         = err_q;
    assign err_timeout = err_to_q;
    assign HTRANS      = htrans;
    assign HBURST      = burst_q;
    assign HSIZE       = size_q;
    assign HWRITE      = write_q;
    assign HADDR       = addr_q;
    assign HWDATA      = hwdata_q;

endmodule

// File: tb/tb_ahb_lite_master.sv
// Directed bench for ahb_lite_master; a tiny slave returns 0xA5A5_0000 | data-phase address.
module tb_ahb_lite_master;

    logic        HCLK = 1'b0;
    logic        HRESET_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_addr = '0;
    logic        cmd_write = 1'b0;
    logic [2:0]  cmd_burst = '0;
    logic [2:0]  cmd_size = '0;
    logic [4:0]  cmd_len = '0;
    logic [31:0] wr_data = '0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        done, err, err_timeout;
    logic [1:0]  HTRANS;
    logic [2:0]  HBURST, HSIZE;
    logic        HWRITE;
    logic [31:0] HADDR, HWDATA, HRDATA;
    logic        HREADY = 1'b1;
    logic [1:0]  HRESP = 2'b00;

    logic [31:0] dp_addr = '0;
    int          wr_cnt = 0;
    int          rdv_cnt = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    int          wr_base, rdv_base;

    ahb_lite_master dut (
        .HCLK        (HCLK),
        .HRESET_n    (HRESET_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_addr    (cmd_addr),
        .cmd_write   (cmd_write),
        .cmd_burst   (cmd_burst),
        .cmd_size    (cmd_size),
        .cmd_len     (cmd_len),
        .wr_data     (wr_data),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .done        (done),
        .err         (err),
        .err_timeout (err_timeout),
        .HTRANS      (HTRANS),
        .HBURST      (HBURST),
        .HSIZE       (HSIZE),
        .HWRITE      (HWRITE),
        .HADDR       (HADDR),
        .HWDATA      (HWDATA),
        .HRDATA      (HRDATA),
        .HREADY      (HREADY),
        .HRESP       (HRESP)
    );

    always #5 HCLK = ~HCLK;

    always @(posedge HCLK) begin
        if (HREADY && HTRANS[1]) dp_addr <= HADDR;
        if (wr_ready) wr_cnt <= wr_cnt + 1;
        if (rd_valid) rdv_cnt <= rdv_cnt + 1;
    end
    assign HRDATA = 32'hA5A5_0000 | dp_addr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge HCLK);
    endtask

    task automatic send(input logic wr, input logic [2:0] burst, input logic [2:0] size,
                        input logic [4:0] len, input logic [31:0] addr);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_burst = burst;
        cmd_size  = size;
        cmd_len   = len;
        cmd_addr  = addr;
    endtask

    initial begin
        // Reset state
        repeat (2) cyc();
        #1;
        chk("rst_htrans", HTRANS, 0);
        chk("rst_haddr", HADDR, 0);
        chk("rst_hwdata", HWDATA, 0);
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_done", done, 0);
        chk("rst_rd_data", rd_data, 0);
        cyc(); HRESET_n = 1'b1; #1;
        chk("cmd_ready_held_low", cmd_ready, 0);
        cyc(); #1;
        chk("cmd_ready_rise", cmd_ready, 1);

        // Write SINGLE 0x10
        cyc(); send(1'b1, 3'b000, 3'd2, 5'd0, 32'h10); wr_valid = 1'b1; wr_data = 32'hDEADBEEF; #1;
        chk("t1_cmd_ready", cmd_ready, 1);
        cyc(); cmd_valid = 1'b0; #1;
        chk("t1_nonseq", HTRANS, 2);
        chk("t1_haddr", HADDR, 32'h10);
        chk("t1_hwrite", HWRITE, 1);
        chk("t1_wr_ready", wr_ready, 1);
        cyc(); wr_valid = 1'b0; #1;
        chk("t1_idle", HTRANS, 0);
        chk("t1_hwdata", HWDATA, 32'hDEADBEEF);
        chk("t1_done_early", done, 0);
        cyc(); #1;
        chk("t1_done", done, 1);
        chk("t1_err", err, 0);
        chk("t1_ready_in_done", cmd_ready, 0);

        // Read WRAP4 0x38
        cyc(); rdv_base = rdv_cnt; send(1'b0, 3'b010, 3'd2, 5'd0, 32'h38); #1;
        chk("t2_cmd_ready", cmd_ready, 1);
        cyc(); cmd_valid = 1'b0; #1;
        chk("t2_nonseq", HTRANS, 2);
        chk("t2_a0", HADDR, 32'h38);
        cyc(); #1;
        chk("t2_seq", HTRANS, 3);
        chk("t2_a1", HADDR, 32'h3C);
        cyc(); #1;
        chk("t2_a2", HADDR, 32'h30);
        chk("t2_rv0", rd_valid, 1);
        chk("t2_rd0", rd_data, 32'hA5A50038);
        cyc(); #1;
        chk("t2_a3", HADDR, 32'h34);
        chk("t2_seq3", HTRANS, 3);
        chk("t2_rd1", rd_data, 32'hA5A5003C);
        cyc(); #1;
        chk("t2_idle", HTRANS, 0);
        chk("t2_rd2", rd_data, 32'hA5A50030);
        cyc(); #1;
        chk("t2_rd3", rd_data, 32'hA5A50034);
        chk("t2_done", done, 1);

        // Write INCR8 0x100 with two BUSY cycles before beat 3
        cyc(); wr_base = wr_cnt; send(1'b1, 3'b101, 3'd2, 5'd0, 32'h100);
        wr_valid = 1'b1; wr_data = 32'h1000_0000; #1;
        chk("t2_rd_count", rdv_cnt - rdv_base, 4);
        cyc(); cmd_valid = 1'b0; #1;
        chk("t3_nonseq", HTRANS, 2);
        chk("t3_a0", HADDR, 32'h100);
        cyc(); wr_data = 32'h1000_0001; #1;
        chk("t3_a1", HADDR, 32'h104);
        chk("t3_wr_ready1", wr_ready, 1);
        cyc(); wr_valid = 1'b0; #1;
        chk("t3_busy1", HTRANS, 1);
        chk("t3_busy1_addr", HADDR, 32'h108);
        chk("t3_busy1_wr_ready", wr_ready, 0);
        chk("t3_hwdata1", HWDATA, 32'h1000_0001);
        cyc(); #1;
        chk("t3_busy2", HTRANS, 1);
        chk("t3_busy2_addr", HADDR, 32'h108);
        for (int i = 2; i < 8; i++) begin
            cyc(); wr_valid = 1'b1; wr_data = 32'h1000_0000 + i; #1;
            chk("t3_seq", HTRANS, 3);
            chk("t3_seq_addr", HADDR, 32'h100 + 4 * i);
        end
        cyc(); wr_valid = 1'b0; #1;
        chk("t3_idle", HTRANS, 0);
        chk("t3_hwdata7", HWDATA, 32'h1000_0007);
        cyc(); #1;
        chk("t3_done", done, 1);
        cyc(); #1;
        chk("t3_wr_count", wr_cnt - wr_base, 8);

        // Read INCR4 0x0 with three wait states on beat 2
        cyc(); send(1'b0, 3'b011, 3'd2, 5'd0, 32'h0); #1;
        chk("t4_cmd_ready", cmd_ready, 1);
        cyc(); cmd_valid = 1'b0; #1;
        chk("t4_nonseq", HTRANS, 2);
        cyc(); #1;
        chk("t4_a1", HADDR, 32'h4);
        cyc(); HREADY = 1'b0; #1;
        chk("t4_a2", HADDR, 32'h8);
        chk("t4_rv0", rd_valid, 1);
        chk("t4_rd0", rd_data, 32'hA5A50000);
        cyc(); #1;
        chk("t4_hold_addr", HADDR, 32'h8);
        chk("t4_hold_trans", HTRANS, 3);
        chk("t4_hold_rv", rd_valid, 0);
        cyc(); #1;
        chk("t4_hold_addr2", HADDR, 32'h8);
        cyc(); HREADY = 1'b1; #1;
        chk("t4_hold_addr3", HADDR, 32'h8);
        chk("t4_hold_rv3", rd_valid, 0);
        cyc(); #1;
        chk("t4_a3", HADDR, 32'hC);
        chk("t4_rd1", rd_data, 32'hA5A50004);
        cyc(); #1;
        chk("t4_idle", HTRANS, 0);
        chk("t4_rd2", rd_data, 32'hA5A50008);
        chk("t4_done_early", done, 0);
        cyc(); #1;
        chk("t4_done", done, 1);
        chk("t4_rd3", rd_data, 32'hA5A5000C);

        // Write INCR4 0x40 with ERROR on beat 2
        cyc(); send(1'b1, 3'b011, 3'd2, 5'd0, 32'h40); wr_valid = 1'b1; wr_data = 32'h5555_0000; #1;
        cyc(); cmd_valid = 1'b0; #1;
        chk("t5_a0", HADDR, 32'h40);
        cyc(); wr_data = 32'h5555_0001; #1;
        chk("t5_a1", HADDR, 32'h44);
        cyc(); HREADY = 1'b0; HRESP = 2'b01; #1;
        chk("t5_err1_wr_ready", wr_ready, 0);
        cyc(); HREADY = 1'b1; #1;
        chk("t5_cancel", HTRANS, 0);
        chk("t5_err2_wr_ready", wr_ready, 0);
        chk("t5_done_early", done, 0);
        cyc(); HRESP = 2'b00; wr_valid = 1'b0; #1;
        chk("t5_done", done, 1);
        chk("t5_err", err, 1);
        chk("t5_err_timeout", err_timeout, 0);
        chk("t5_idle", HTRANS, 0);
        cyc(); #1;
        chk("t5_no_more_beats", HTRANS, 0);
        chk("t5_cmd_ready", cmd_ready, 1);

        // Illegal commands
        cyc(); send(1'b0, 3'b110, 3'd2, 5'd0, 32'h0); #1;
        cyc(); cmd_valid = 1'b0; #1;
        chk("t6_no_traffic", HTRANS, 0);
        chk("t6_done", done, 1);
        chk("t6_err", err, 1);
        cyc(); #1;
        chk("t6_done_clear", done, 0);
        chk("t6_cmd_ready", cmd_ready, 1);
        cyc(); send(1'b0, 3'b000, 3'd2, 5'd0, 32'h2); #1;
        cyc(); cmd_valid = 1'b0; #1;
        chk("t6_misalign_done", done, 1);
        chk("t6_misalign_err", err, 1);
        chk("t6_misalign_idle", HTRANS, 0);
        cyc();

        // INCR len 2, halfword
        cyc(); send(1'b0, 3'b001, 3'd1, 5'd2, 32'h20); #1;
        chk("t7_cmd_ready", cmd_ready, 1);
        cyc(); cmd_valid = 1'b0; #1;
        chk("t7_a0", HADDR, 32'h20);
        chk("t7_hsize", HSIZE, 1);
        cyc(); #1;
        chk("t7_a1", HADDR, 32'h22);
        cyc(); #1;
        chk("t7_idle", HTRANS, 0);
        chk("t7_rd0", rd_data, 32'hA5A50020);
        cyc(); #1;
        chk("t7_done", done, 1);
        chk("t7_rd1", rd_data, 32'hA5A50022);

        // Reset in mid-burst
        cyc(); send(1'b0, 3'b011, 3'd2, 5'd0, 32'h80); #1;
        cyc(); cmd_valid = 1'b0; #1;
        cyc(); #1;
        chk("t8_a1", HADDR, 32'h84);
        HRESET_n = 1'b0; #1;
        chk("t8_rst_idle", HTRANS, 0);
        cyc(); HRESET_n = 1'b1; #1;
        chk("t8_no_done", done, 0);
        cyc(); #1;
        chk("t8_cmd_ready", cmd_ready, 1);
        chk("t8_idle", HTRANS, 0);

`ifdef AHB_MASTER_TIMEOUT_EN
        // Stuck HREADY aborts after 16 low data-phase cycles
        begin
            int waited;
            waited = 0;
            cyc(); send(1'b1, 3'b000, 3'd2, 5'd0, 32'h60); wr_valid = 1'b1; #1;
            cyc(); cmd_valid = 1'b0; #1;
            chk("t9_nonseq", HTRANS, 2);
            cyc(); wr_valid = 1'b0; HREADY = 1'b0; #1;
            while (!done && waited < 40) begin
                cyc(); #1;
                waited++;
            end
            chk("t9_wait_cycles", waited, 16);
            chk("t9_err", err, 1);
            chk("t9_err_timeout", err_timeout, 1);
            chk("t9_idle", HTRANS, 0);
            HREADY = 1'b1;
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
